// File: rtl/axi_lite_regtest_master_if.sv
// ---------------------------------------------------------------------------
// axi_lite_regtest_master_if
//   AXI4-Lite bundle used between the register self-test master and the
//   slave under test. Carries the five channels (AW, W, B, AR, R).
//   Clock and reset are not part of the bundle; they stay plain module ports.
//
//   Parameters
//     ADDR_WIDTH  width of AWADDR / ARADDR
//     DATA_WIDTH  width of WDATA / RDATA (WSTRB is DATA_WIDTH/8)
//
//   Modports
//     master : drives AW/W/AR payload + VALID, BREADY, RREADY
//     slave  : drives AWREADY, WREADY, ARREADY, B and R channels
// ---------------------------------------------------------------------------
interface axi_lite_regtest_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_lite_regtest_master.sv
// ---------------------------------------------------------------------------
// axi_lite_regtest_master
//   AXI4-Lite master that write/readback-tests a bank of NUM_REGS slave
//   registers and reports pass/fail. Register i lives at
//   BASE_ADDR + i*ADDR_STRIDE and is tested with data PAT_SEED + i*PAT_INCR.
//
//   Modes (sampled on start):
//     0 : per register, write then read back
//     1 : write all registers, then read all back
//     2 : read-only check of all registers
//     3 : treated as mode 0
//
//   Ports
//     ACLK           clock
//     ARESET         synchronous reset, active high
//     start          one-cycle pulse; begins a run when idle
//     mode[1:0]      test mode, see above
//     busy           run in progress
//     done           one-cycle pulse at end of run
//     pass           last run had zero errors (held until next start)
//     err_count[7:0] errors in last run, saturating at 255
//     first_err_idx  register index of first error, 0 when none
//     m_axi          AXI4-Lite master bundle
//
//   Only one AXI transaction is ever outstanding, so a read is never issued
//   before the B response of the preceding write.
// ---------------------------------------------------------------------------
module axi_lite_regtest_master #(
  parameter int unsigned                    C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                    C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                    NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  BASE_ADDR          = '0,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  ADDR_STRIDE        = C_M_AXI_ADDR_WIDTH'(4),
  parameter logic [31:0]                    PAT_SEED           = 32'h0101FFFF,
  parameter logic [31:0]                    PAT_INCR           = 32'h11110011
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  input  logic [1:0]                        mode,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [7:0]                        err_count,
  output logic [7:0]                        first_err_idx,
  axi_lite_regtest_master_if.master         m_axi
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

  // Patterns are zero-extended to the data width; the running sum then
  // wraps modulo 2^DW naturally.
  localparam logic [DW-1:0] SEED_X   = DW'(PAT_SEED);
  localparam logic [DW-1:0] INCR_X   = DW'(PAT_INCR);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] MODE_INTERLEAVE = 2'd0;
  localparam logic [1:0] MODE_WR_ALL     = 2'd1;
  localparam logic [1:0] MODE_RD_ONLY    = 2'd2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    idx_q, idx_d;
  // Address and pattern are kept as running sums so no multiplier is needed;
  // they only change between requests, so payloads stay stable while VALID.
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] pat_q, pat_d;
  // Per-channel completion flags let AW and W drop independently.
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [7:0]    first_err_q, first_err_d;
  logic          pass_q, pass_d;

  logic          awvalid_int, wvalid_int, arvalid_int;
  logic          bready_int, rready_int;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          is_last;
  logic          beat_err;

  // Handshake strobes and channel controls are decoded from registered
  // state only, so no VALID depends combinationally on a READY.
  assign awvalid_int = (state_q == S_WR_REQ) && !aw_done_q;
  assign wvalid_int  = (state_q == S_WR_REQ) && !w_done_q;
  assign bready_int  = (state_q == S_WR_RESP);
  assign arvalid_int = (state_q == S_RD_REQ);
  assign rready_int  = (state_q == S_RD_DATA);

  assign aw_hs = awvalid_int && m_axi.awready;
  assign w_hs  = wvalid_int  && m_axi.wready;
  assign b_hs  = bready_int  && m_axi.bvalid;
  assign ar_hs = arvalid_int && m_axi.arready;
  assign r_hs  = rready_int  && m_axi.rvalid;

  assign is_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    pat_d       = pat_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    beat_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_count_d = 8'd0;
          first_err_d = 8'd0;
          pass_d      = 1'b0;
          idx_d       = 8'd0;
          addr_d      = BASE_ADDR;
          pat_d       = SEED_X;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          mode_d      = (mode == 2'd3) ? MODE_INTERLEAVE : mode;
          state_d     = (mode == MODE_RD_ONLY) ? S_RD_REQ : S_WR_REQ;
        end
      end

      S_WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          // Flags cleared on exit so every WR_REQ entry starts fresh.
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (b_hs) begin
          if (m_axi.bresp != RESP_OKAY) beat_err = 1'b1;
          if (mode_q == MODE_WR_ALL) begin
            if (is_last) begin
              // Write phase complete: rewind to register 0 for readback.
              idx_d   = 8'd0;
              addr_d  = BASE_ADDR;
              pat_d   = SEED_X;
              state_d = S_RD_REQ;
            end else begin
              idx_d   = idx_q + 8'd1;
              addr_d  = addr_q + ADDR_STRIDE;
              pat_d   = pat_q + INCR_X;
              state_d = S_WR_REQ;
            end
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (ar_hs) state_d = S_RD_DATA;
      end

      S_RD_DATA: begin
        if (r_hs) begin
          // A bad response and a data mismatch on the same beat count once.
          if ((m_axi.rresp != RESP_OKAY) || (m_axi.rdata != pat_q)) beat_err = 1'b1;
          if (is_last) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 8'd1;
            addr_d  = addr_q + ADDR_STRIDE;
            pat_d   = pat_q + INCR_X;
            state_d = (mode_q == MODE_INTERLEAVE) ? S_WR_REQ : S_RD_REQ;
          end
        end
      end

      S_FINISH: begin
        // No beat is accepted in FINISH, so err_count_q is already final.
        pass_d  = (err_count_q == 8'd0);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (beat_err) begin
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      // err_count never returns to zero within a run, so zero marks "first".
      if (err_count_q == 8'd0) first_err_d = idx_q;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_INTERLEAVE;
      idx_q       <= 8'd0;
      addr_q      <= BASE_ADDR;
      pat_q       <= SEED_X;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_count_q <= 8'd0;
      first_err_q <= 8'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  // Status outputs
  assign busy          = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done          = (state_q == S_FINISH);
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

  // AXI outputs
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_int;
  assign m_axi.wdata   = pat_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_int;
  assign m_axi.bready  = bready_int;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_int;
  assign m_axi.rready  = rready_int;

endmodule

// File: tb/tb_axi_lite_regtest_master.sv
module tb_axi_lite_regtest_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       ACLK   = 1'b0;
  logic       ARESET = 1'b1;
  logic       start  = 1'b0;
  logic [1:0] mode   = 2'd0;
  logic       busy, done, pass;
  logic [7:0] err_count, first_err_idx;

  axi_lite_regtest_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_regtest_master dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .start         (start),
    .mode          (mode),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .m_axi         (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model: 4-register RAM with knobs ----------------
  int aw_dly = 0;
  int w_dly = 0;
  bit slverr = 1'b0;
  int corrupt_idx = -1;

  logic [DW-1:0] mem [4];
  int            aw_wait, w_wait;
  logic          aw_got, w_got;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;
  logic          s_bvalid, s_rvalid;
  logic [1:0]    s_bresp;
  logic [DW-1:0] s_rdata;

  assign bus.awready = !aw_got && (aw_wait >= aw_dly);
  assign bus.wready  = !w_got && (w_wait >= w_dly);
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.arready = !s_rvalid;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = 2'b00;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rdata <= '0;
      s_awaddr <= '0; s_wdata <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (bus.awvalid) begin
        if (bus.awready) begin aw_got <= 1'b1; s_awaddr <= bus.awaddr; aw_wait <= 0; end
        else aw_wait <= aw_wait + 1;
      end
      if (bus.wvalid) begin
        if (bus.wready) begin w_got <= 1'b1; s_wdata <= bus.wdata; w_wait <= 0; end
        else w_wait <= w_wait + 1;
      end
      if (aw_got && w_got && !s_bvalid) begin
        mem[s_awaddr[3:2]] <= s_wdata;
        s_bvalid <= 1'b1;
        s_bresp  <= slverr ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else if (s_bvalid && bus.bready) begin
        s_bvalid <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[bus.araddr[3:2]] ^
                    ((int'(bus.araddr[3:2]) == corrupt_idx) ? 32'h1 : 32'h0);
      end else if (s_rvalid && bus.rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic mon_clr = 1'b0;
  int   n_aw, n_w, n_b, n_ar, n_done, b_at_first_ar;
  bit   ar_seen, w_only_seen, order_viol, stable_viol;
  logic prev_aw_stall, prev_w_stall, prev_ar_stall;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [DW-1:0] prev_wdata;

  always @(posedge ACLK) begin
    if (mon_clr) begin
      n_aw <= 0; n_w <= 0; n_b <= 0; n_ar <= 0; n_done <= 0; b_at_first_ar <= 0;
      ar_seen <= 1'b0; w_only_seen <= 1'b0; order_viol <= 1'b0; stable_viol <= 1'b0;
      prev_aw_stall <= 1'b0; prev_w_stall <= 1'b0; prev_ar_stall <= 1'b0;
      prev_awaddr <= '0; prev_araddr <= '0; prev_wdata <= '0;
    end else begin
      if (bus.awvalid && bus.awready) n_aw <= n_aw + 1;
      if (bus.wvalid && bus.wready) n_w <= n_w + 1;
      if (bus.bvalid && bus.bready) n_b <= n_b + 1;
      if (bus.arvalid && bus.arready) begin
        n_ar <= n_ar + 1;
        if (!ar_seen) begin ar_seen <= 1'b1; b_at_first_ar <= n_b; end
        if (n_aw != n_b) order_viol <= 1'b1;
      end
      if (done) n_done <= n_done + 1;
      if (!bus.awvalid && bus.wvalid) w_only_seen <= 1'b1;
      if (prev_aw_stall && (!bus.awvalid || bus.awaddr != prev_awaddr)) stable_viol <= 1'b1;
      if (prev_w_stall && (!bus.wvalid || bus.wdata != prev_wdata)) stable_viol <= 1'b1;
      if (prev_ar_stall && (!bus.arvalid || bus.araddr != prev_araddr)) stable_viol <= 1'b1;
      prev_aw_stall <= bus.awvalid && !bus.awready;
      prev_w_stall  <= bus.wvalid && !bus.wready;
      prev_ar_stall <= bus.arvalid && !bus.arready;
      prev_awaddr   <= bus.awaddr;
      prev_wdata    <= bus.wdata;
      prev_araddr   <= bus.araddr;
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge ACLK); #1;
    mon_clr = 1'b0;
  endtask

  // Pulse start, re-pulse while busy (must be ignored), wait for done.
  task automatic run(input logic [1:0] m);
    clear_mon();
    mode  = m;
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("pass_cleared", pass, 0);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) break;
      @(posedge ACLK); #1;
    end
    check("done_seen", done, 1);
    @(posedge ACLK); #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    repeat (3) @(posedge ACLK);
    #1;
  endtask

  // ---------------- test table ----------------
  typedef struct {
    string      name;
    logic [1:0] mode;
    int         aw_dly;
    int         w_dly;
    bit         slverr;
    int         corrupt;
    bit         check_mem;
    bit         exp_pass;
    int         exp_err;
    int         exp_first;
    int         exp_wr;
    int         exp_rd;
    int         exp_b_first_ar;
    bit         exp_w_only;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] exp_pat [4];

  initial begin
    // data_i = PAT_SEED + i*PAT_INCR (mod 2^32)
    exp_pat[0] = 32'h0101FFFF;
    exp_pat[1] = 32'h12130010;
    exp_pat[2] = 32'h23240021;
    exp_pat[3] = 32'h34350032;

    //          name              mode aw w slv cor mem pass err first wr rd bfa wonly
    vecs[0] = '{"T1_mode0",       2'd0, 0, 0, 0, -1, 1, 1, 0, 0, 4, 4, 1, 0};
    vecs[1] = '{"T4_mode2",       2'd2, 0, 0, 0, -1, 0, 1, 0, 0, 0, 4, 0, 0};
    vecs[2] = '{"T2_mode1_split", 2'd1, 1, 4, 0, -1, 1, 1, 0, 0, 4, 4, 4, 1};
    vecs[3] = '{"T3_corrupt2",    2'd0, 0, 0, 0,  2, 0, 0, 1, 2, 4, 4, 1, 0};
    vecs[4] = '{"T5_slverr",      2'd0, 0, 0, 1, -1, 0, 0, 4, 0, 4, 4, 1, 0};
    vecs[5] = '{"mode2_corrupt0", 2'd2, 0, 0, 0,  0, 0, 0, 1, 0, 0, 4, 0, 0};
    vecs[6] = '{"mode3_corrupt3", 2'd3, 0, 0, 0,  3, 0, 0, 1, 3, 4, 4, 1, 0};

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_bready", bus.bready, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err", first_err_idx, 0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    for (int v = 0; v < 7; v++) begin
      aw_dly      = vecs[v].aw_dly;
      w_dly       = vecs[v].w_dly;
      slverr      = vecs[v].slverr;
      corrupt_idx = vecs[v].corrupt;
      run(vecs[v].mode);
      $display("run %s mode=%0d pass=%0d err_count=%0d first_err_idx=%0d aw=%0d ar=%0d",
               vecs[v].name, vecs[v].mode, pass, err_count, first_err_idx, n_aw, n_ar);
      check({vecs[v].name, "_pass"}, pass, vecs[v].exp_pass);
      check({vecs[v].name, "_err_count"}, err_count, vecs[v].exp_err);
      check({vecs[v].name, "_first_err"}, first_err_idx, vecs[v].exp_first);
      check({vecs[v].name, "_aw_count"}, n_aw, vecs[v].exp_wr);
      check({vecs[v].name, "_w_count"}, n_w, vecs[v].exp_wr);
      check({vecs[v].name, "_b_count"}, n_b, vecs[v].exp_wr);
      check({vecs[v].name, "_ar_count"}, n_ar, vecs[v].exp_rd);
      check({vecs[v].name, "_b_before_first_ar"}, b_at_first_ar, vecs[v].exp_b_first_ar);
      check({vecs[v].name, "_w_only_cycle"}, w_only_seen, vecs[v].exp_w_only);
      check({vecs[v].name, "_done_pulses"}, n_done, 1);
      check({vecs[v].name, "_order_viol"}, order_viol, 0);
      check({vecs[v].name, "_stable_viol"}, stable_viol, 0);
      if (vecs[v].check_mem)
        for (int i = 0; i < 4; i++) check($sformatf("%s_mem%0d", vecs[v].name, i), mem[i], exp_pat[i]);
    end

    // T6: reset in the middle of WR_REQ, then a fresh run
    slverr = 1'b0; corrupt_idx = -1; aw_dly = 6; w_dly = 6;
    clear_mon();
    mode  = 2'd0;
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.awvalid) break;
      @(posedge ACLK); #1;
    end
    check("T6_awvalid_before_reset", bus.awvalid, 1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("T6_awvalid", bus.awvalid, 0);
    check("T6_wvalid", bus.wvalid, 0);
    check("T6_arvalid", bus.arvalid, 0);
    check("T6_bready", bus.bready, 0);
    check("T6_rready", bus.rready, 0);
    check("T6_busy", busy, 0);
    check("T6_pass", pass, 0);
    check("T6_err_count", err_count, 0);
    ARESET = 1'b0;
    aw_dly = 0; w_dly = 0;
    @(posedge ACLK); #1;
    run(2'd0);
    $display("run T6_fresh mode=0 pass=%0d err_count=%0d first_err_idx=%0d aw=%0d ar=%0d",
             pass, err_count, first_err_idx, n_aw, n_ar);
    check("T6_fresh_pass", pass, 1);
    check("T6_fresh_err_count", err_count, 0);
    check("T6_fresh_aw_count", n_aw, 4);
    check("T6_fresh_ar_count", n_ar, 4);
    for (int i = 0; i < 4; i++) check($sformatf("T6_mem%0d", i), mem[i], exp_pat[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
